// File: rtl/cpu_pkg.sv
// Types and constants shared by the fetch stage and the modules around it.
package cpu_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory read port: req/addr held until gnt, one rvalid per grant at least a cycle later.
interface if_fetch_unit_if;

    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);

endinterface

// File: rtl/fetch_buf.sv
// Small synchronous FIFO of fetched (pc, instr) pairs; clear wins over push.
module fetch_buf
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  fetch_entry_t entry_i,
    input  logic         pop_i,
    input  logic         clear_i,
    output fetch_entry_t head_o,
    output logic [CW-1:0] count_o
);

    fetch_entry_t    mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    always_comb begin
        wr_ptr_d = push_i ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_i ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= entry_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, keeps one imem read in flight and buffers returned words.
module if_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              stall2_i,
    input  logic              flush_i,
    input  logic [31:0]       branch_target_i,
    if_fetch_unit_if.master   imem,
    output logic [31:0]       pc_o,
    output logic [31:0]       instr_o,
    output logic              fetch_valid_o,
    output fetch_state_t      state_o
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_t  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   inflight_pc_q, inflight_pc_d;

    logic [CW-1:0] count;
    logic [CW-1:0] occupancy;
    fetch_entry_t  head;
    logic          space, req, fire, push, pop, buf_valid;

    fetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .entry_i ('{pc: inflight_pc_q, instr: imem.rdata}),
        .pop_i   (pop),
        .clear_i (flush_i),
        .head_o  (head),
        .count_o (count)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (fire) state_d = WAIT;
            WAIT: begin
                if (flush_i) begin
                    state_d = imem.rvalid ? IDLE : DROP;
                end else if (imem.rvalid) begin
                    state_d = fire ? WAIT : IDLE;
                end
            end
            DROP: if (imem.rvalid) state_d = fire ? WAIT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // An outstanding read reserves a buffer slot, so the buffer can never overflow.
    always_comb begin
        occupancy = count + CW'(state_q != IDLE);
        space     = occupancy < CW'(BUF_DEPTH);
        req       = !rst_i && !flush_i && space && (state_q == IDLE || imem.rvalid);
        fire      = req && imem.gnt;
        push      = (state_q == WAIT) && imem.rvalid && !flush_i;
        buf_valid = (count != '0);
        pop       = buf_valid && !stall_i && !stall2_i && !flush_i;
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        if (flush_i) begin
            fetch_pc_d = {branch_target_i[31:2], 2'b00};
        end else if (fire) begin
            fetch_pc_d    = fetch_pc_q + 32'd4;
            inflight_pc_d = fetch_pc_q;
        end
    end

    assign imem.req      = req;
    assign imem.addr     = fetch_pc_q;
    assign fetch_valid_o = buf_valid;
    assign pc_o          = buf_valid ? head.pc : 32'h0;
    assign instr_o       = buf_valid ? head.instr : NOP_INSTR;
    assign state_o       = state_q;

endmodule
